activity_led_driver: RTL

ACTIVITY_LED_DRIVER -- requirements
Module: activity_led_driver

---
 rtl/activity_led_driver.sv | 100 ++++++++++
 1 files changed

// File: rtl/activity_led_driver.sv
// activity_led_driver: stretches per-port MIDI activity into LED bits and streams them to a 74HC595 chain.
module activity_led_driver #(
  parameter int PORTS   = 16,
  parameter int CLOCK   = 12_000_000,
  parameter int HOLD_MS = 50,
  parameter int SCK_DIV = 4,
  parameter bit INVERT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] activity_in,
  input  logic [PORTS-1:0] activity_out,
  input  logic             lamp_test,
  output logic             sck,
  output logic             rck,
  output logic             ser,
  output logic             frame_done
);
  localparam int N   = 2 * PORTS;
  localparam int DIV = CLOCK / 1000;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW  = N > 1 ? $clog2(N) : 1;
  localparam int DW  = $clog2(2 * SCK_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [N-1:0][7:0]   hold_q, hold_d;
  logic [N-1:0]        act, led, sr_q, sr_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DW-1:0]       div_q, div_d;
  logic                ms_tick, bit_end, lat_end;

  assign ms_tick = pre_q == PW'(DIV - 1);
  assign pre_d   = ms_tick ? '0 : pre_q + 1'b1;
  assign act     = {activity_out, activity_in};

  // A fresh activity pulse reloads the stretch even on a tick cycle.
  for (genvar i = 0; i < N; i++) begin : g_hold
    assign hold_d[i] = act[i] ? 8'(HOLD_MS) :
                       (ms_tick && hold_q[i] != 8'd0) ? hold_q[i] - 8'd1 : hold_q[i];
    assign led[i]    = hold_q[i] != 8'd0;
  end

  assign bit_end = div_q == DW'(2 * SCK_DIV - 1);
  assign lat_end = div_q == DW'(SCK_DIV - 1);

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        state_d = SHIFT;
        bit_d   = '0;
        sr_d    = lamp_test ? '1 : led;
      end
      SHIFT: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (bit_end) begin
          sr_d    = sr_q << 1;
          bit_d   = bit_q + 1'b1;
          state_d = bit_q == BW'(N - 1) ? LATCH : SHIFT;
        end
      end
      LATCH: begin
        div_d   = lat_end ? '0 : div_q + 1'b1;
        state_d = lat_end ? IDLE : LATCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      hold_q  <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  // Outputs decode straight from registered state so reset forces them at once.
  assign sck        = state_q == SHIFT && div_q >= DW'(SCK_DIV);
  assign rck        = state_q == LATCH;
  assign ser        = (state_q == SHIFT ? sr_q[N-1] : 1'b0) ^ INVERT;
  assign frame_done = state_q == LATCH && lat_end;
endmodule
